ntt_dispatcher: RTL and testbench
=================================

# ntt_dispatcher

Command dispatcher for the NTT datapath. It accepts 64-bit command words from the host side over a valid/ready interface and buffers them in a small FIFO. Each NTT/INTT command is issued to the NTT engine as a start pulse with mode and address, and the dispatcher waits for the engine's done pulse before issuing the next. It also handles NOP, HALT and illegal opcodes, and keeps a completed-operation counter plus sticky error flags.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, ≥2
- TIMEOUT_CYCLES, 1048576, max cycles in WAIT before abort; ≥1
- CNT_W, 16, width of op_count

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_data  in  64  [63:56] opcode, [55:0] payload (address)
- cmd_ready  out  1  FIFO can accept a word
- ntt_start  out  1  one-cycle start pulse to NTT engine
- ntt_mode  out  1  0 = forward NTT, 1 = inverse
- ntt_addr  out  56  DMA address for the engine
- ntt_done  in  1  engine completion pulse
- halted  out  1  HALT executed
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- err_illegal  out  1  sticky; an illegal opcode was popped
- err_timeout  out  1  sticky; WAIT exceeded TIMEOUT_CYCLES
- op_count  out  CNT_W  completed NTT/INTT operations, wraps
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- **Opcodes:**
  - 0x00 NOP
  - 0x01 NTT, mode 0
  - 0x02 INTT, mode 1
  - 0xFF HALT
  - Anything else is illegal.
- **FIFO:**
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !full && !halted. A push is refused when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Read/write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT, HALTED.
  - **IDLE, FIFO non-empty:** pop the head word and decode it.
    - NTT/INTT: latch mode and addr, go to ISSUE.
    - NOP: stay in IDLE.
    - HALT: go to HALTED.
    - Illegal: set err_illegal, stay in IDLE; the word is discarded.
  - **ISSUE:** ntt_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - **WAIT:** the timeout counter increments each cycle.
    - ntt_done = 1: op_count += 1 (wraps), go to IDLE.
    - Counter reaches TIMEOUT_CYCLES with no done: set err_timeout, go to IDLE; op_count unchanged.
    - If done and timeout occur in the same cycle, done wins.
  - **HALTED:** halted = 1 and cmd_ready = 0. Exit only by rst. Remaining FIFO contents are not popped.
- ntt_done is ignored outside WAIT, including the ISSUE cycle.
- ntt_mode and ntt_addr are held stable from ISSUE until the next ISSUE.
- Error flags are sticky until rst.

## Timing
- **Reset values** (async assert, deasserted synchronously by the system):
  - ntt_start = 0, ntt_mode = 0, ntt_addr = 0
  - halted = 0, busy = 0, err_illegal = 0, err_timeout = 0
  - op_count = 0, fifo_level = 0
  - cmd_ready = 1, FSM in IDLE, FIFO empty
- **Reset mid-operation:** FIFO is flushed, the in-flight command is abandoned, and no start pulse follows reset.
- **Pipeline latency:** a word pushed at edge t is visible in the FIFO at cycle t+1. IDLE pops it at t+1, and ntt_start is high during cycle t+2.
- **Issue rate:** one pop per IDLE cycle at most. After done is sampled at cycle d, the next start is no earlier than d+2.
- **Pop-to-effect:** NOP and illegal words consume one IDLE cycle each. HALT reaches HALTED one cycle after the pop.
- **Registered outputs:** all outputs are registered except cmd_ready, busy and fifo_level, which are combinational from registered state.

## Test plan
- **Single NTT:** reset; push 0x01_00000000001000 → ntt_start is high one cycle, 2 cycles after the push, with mode 0 and addr 0x1000. Done 10 cycles later → op_count = 1, busy = 0.
- **Fill/backpressure:** DEPTH = 4; hold ntt_done = 0 and push 6 INTT words → cmd_ready drops after 5 accepts (1 in flight + 4 buffered), fifo_level = 4. Then pulse done 5 times → 5 starts, each with mode 1, op_count = 5.
- **Mixed stream:** push NOP, 0x7A illegal, NTT 0x20 → err_illegal = 1, and exactly one start with addr 0x20.
- **Halt:** push NTT, HALT, NTT; complete the first → halted = 1, cmd_ready = 0, no second start, fifo_level = 1.
- **Timeout:** TIMEOUT_CYCLES = 8; issue NTT with no done → err_timeout = 1 after 8 WAIT cycles, op_count = 0, and the next queued command issues. A stray done pulse while in IDLE is ignored.
- **Reset mid-WAIT:** assert rst while in WAIT with 2 words queued → all outputs return to reset values immediately, fifo_level = 0, and no start pulse follows.

Source files
------------

// File: rtl/ntt_dispatcher_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntt_dispatcher_if : host command channel and NTT engine handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ntt_dispatcher_if;
   logic        cmd_valid;
   logic [63:0] cmd_data;
   logic        cmd_ready;
   logic        ntt_start;
   logic        ntt_mode;
   logic [55:0] ntt_addr;
   logic        ntt_done;

   // master is the surrounding system (host + engine); slave is the dispatcher
   modport master (
      output cmd_valid, cmd_data, ntt_done,
      input  cmd_ready, ntt_start, ntt_mode, ntt_addr
   );

   modport slave (
      input  cmd_valid, cmd_data, ntt_done,
      output cmd_ready, ntt_start, ntt_mode, ntt_addr
   );
endinterface
`default_nettype wire

// File: rtl/ntt_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntt_dispatcher : FIFO-buffered command dispatcher for the NTT engine
// Revision: 1.0
// ----------------------------------------------------------------------------
module ntt_dispatcher #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_W          = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   ntt_dispatcher_if.slave              bus,
   output logic                         halted,
   output logic                         busy,
   output logic                         err_illegal,
   output logic                         err_timeout,
   output logic [CNT_W-1:0]             op_count,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_NTT  = 8'h01;
   localparam logic [7:0] OP_INTT = 8'h02;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t             state;
   logic [63:0]        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;
   logic [TMO_W-1:0]   tmo_cnt;

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [63:0]        head;
   logic [7:0]         opcode;

   assign full   = (level == LVL_W'(DEPTH));
   assign empty  = (level == '0);
   // a full FIFO refuses a push even when a pop frees a slot this cycle
   assign bus.cmd_ready = !full && !halted;
   assign push   = bus.cmd_valid && bus.cmd_ready;
   assign pop    = (state == IDLE) && !empty;
   assign head   = mem[rd_ptr];
   assign opcode = head[63:56];

   assign busy       = (state != IDLE) || !empty;
   assign fifo_level = level;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.cmd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tmo_cnt      <= '0;
         bus.ntt_start <= 1'b0;
         bus.ntt_mode  <= 1'b0;
         bus.ntt_addr  <= '0;
         halted       <= 1'b0;
         err_illegal  <= 1'b0;
         err_timeout  <= 1'b0;
         op_count     <= '0;
      end else begin
         bus.ntt_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  case (opcode)
                     OP_NTT, OP_INTT: begin
                        bus.ntt_mode  <= (opcode == OP_INTT);
                        bus.ntt_addr  <= head[55:0];
                        bus.ntt_start <= 1'b1;
                        state         <= ISSUE;
                     end
                     OP_NOP: begin
                        state <= IDLE;
                     end
                     OP_HALT: begin
                        halted <= 1'b1;
                        state  <= HALTED;
                     end
                     default: begin
                        err_illegal <= 1'b1;
                     end
                  endcase
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // done takes priority over a timeout landing in the same cycle
               if (bus.ntt_done) begin
                  op_count <= op_count + CNT_W'(1);
                  state    <= IDLE;
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ntt_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ntt_dispatcher : scoreboard bench for ntt_dispatcher
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ntt_dispatcher;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              halted;
   logic              busy;
   logic              err_illegal;
   logic              err_timeout;
   logic [CNT_W-1:0]  op_count;
   logic [2:0]        fifo_level;

   ntt_dispatcher_if bus();

   ntt_dispatcher #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .halted      (halted),
      .busy        (busy),
      .err_illegal (err_illegal),
      .err_timeout (err_timeout),
      .op_count    (op_count),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   int          n_checks  = 0;
   int          n_fail    = 0;
   int          cyc       = 0;
   int          start_cnt = 0;
   int          start_cyc = 0;
   int          push_cyc  = 0;
   logic        prev_start = 1'b0;
   logic [56:0] sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // every start pulse must match the oldest expected command
   always @(negedge clk) begin
      logic [56:0] exp_cmd;
      if (!rst && bus.ntt_start) begin
         check("start_width", 64'(prev_start), 64'd0);
         if (sb.size() == 0) begin
            check("start_unexpected", 64'(sb.size()), 64'd1);
         end else begin
            exp_cmd = sb.pop_front();
            check("start_cmd", 64'({bus.ntt_mode, bus.ntt_addr}), 64'(exp_cmd));
         end
         start_cnt++;
         start_cyc = cyc;
      end
      prev_start = bus.ntt_start;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state();
      check("rst_start",    64'(bus.ntt_start), 64'd0);
      check("rst_mode",     64'(bus.ntt_mode),  64'd0);
      check("rst_addr",     64'(bus.ntt_addr),  64'd0);
      check("rst_halted",   64'(halted),        64'd0);
      check("rst_busy",     64'(busy),          64'd0);
      check("rst_illegal",  64'(err_illegal),   64'd0);
      check("rst_timeout",  64'(err_timeout),   64'd0);
      check("rst_op_count", 64'(op_count),      64'd0);
      check("rst_level",    64'(fifo_level),    64'd0);
      check("rst_ready",    64'(bus.cmd_ready), 64'd1);
   endtask

   task automatic do_reset();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.ntt_done  = 1'b0;
      rst = 1'b1;
      #1;
      tick(2);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic push_word(input logic [63:0] w, input bit expect_issue);
      int b = 0;
      while (!bus.cmd_ready && b < 50) begin
         tick(1);
         b++;
      end
      check("push_ready", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = w;
      if (expect_issue) sb.push_back({(w[63:56] == 8'h02), w[55:0]});
      tick(1);
      push_cyc = cyc;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_starts(input int n);
      int b = 0;
      while (start_cnt < n && b < 100) begin
         tick(1);
         b++;
      end
      check("start_seen", 64'(start_cnt), 64'(n));
   endtask

   task automatic pulse_done();
      bus.ntt_done = 1'b1;
      tick(1);
      bus.ntt_done = 1'b0;
   endtask

   initial begin
      int base;
      int accepted;
      logic rdy;
      logic [63:0] w;

      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.ntt_done  = 1'b0;
      #2;
      check_reset_state();

      // single NTT
      do_reset();
      base = start_cnt;
      push_word(64'h01_00000000001000, 1'b1);
      wait_starts(base + 1);
      check("start_latency", 64'(start_cyc - push_cyc), 64'd1);
      tick(4);
      pulse_done();
      tick(2);
      check("single_op_count", 64'(op_count), 64'd1);
      check("single_busy", 64'(busy), 64'd0);

      // fill and backpressure
      do_reset();
      base = start_cnt;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         w = {8'h02, 56'(32'h100 + i * 16)};
         bus.cmd_valid = 1'b1;
         bus.cmd_data  = w;
         rdy = bus.cmd_ready;
         tick(1);
         if (rdy) begin
            accepted++;
            sb.push_back({1'b1, w[55:0]});
         end
      end
      bus.cmd_valid = 1'b0;
      check("fill_accepted", 64'(accepted), 64'd5);
      check("fill_ready", 64'(bus.cmd_ready), 64'd0);
      check("fill_level", 64'(fifo_level), 64'd4);
      for (int k = 1; k <= 5; k++) begin
         wait_starts(base + k);
         pulse_done();
      end
      tick(2);
      check("fill_op_count", 64'(op_count), 64'd5);
      check("fill_starts", 64'(start_cnt - base), 64'd5);
      check("fill_sb_empty", 64'(sb.size()), 64'd0);
      check("fill_busy", 64'(busy), 64'd0);

      // mixed NOP / illegal / NTT
      do_reset();
      base = start_cnt;
      push_word(64'h00_00000000000000, 1'b0);
      push_word(64'h7A_00000000000011, 1'b0);
      push_word(64'h01_00000000000020, 1'b1);
      wait_starts(base + 1);
      pulse_done();
      tick(3);
      check("mixed_illegal", 64'(err_illegal), 64'd1);
      check("mixed_starts", 64'(start_cnt - base), 64'd1);
      check("mixed_op_count", 64'(op_count), 64'd1);

      // halt with a command left behind
      do_reset();
      base = start_cnt;
      push_word(64'h01_00000000003000, 1'b1);
      push_word(64'hFF_00000000000000, 1'b0);
      push_word(64'h01_00000000004000, 1'b0);
      wait_starts(base + 1);
      pulse_done();
      tick(5);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_ready", 64'(bus.cmd_ready), 64'd0);
      check("halt_level", 64'(fifo_level), 64'd1);
      check("halt_busy", 64'(busy), 64'd1);
      check("halt_starts", 64'(start_cnt - base), 64'd1);

      // timeout after TMO wait cycles, then next command issues
      do_reset();
      base = start_cnt;
      push_word(64'h01_00000000005000, 1'b1);
      push_word(64'h02_00000000006000, 1'b1);
      wait_starts(base + 1);
      tick(7);
      check("tmo_early", 64'(err_timeout), 64'd0);
      tick(1);
      check("tmo_flag", 64'(err_timeout), 64'd1);
      check("tmo_op_count", 64'(op_count), 64'd0);
      wait_starts(base + 2);
      pulse_done();
      tick(2);
      check("tmo_next_done", 64'(op_count), 64'd1);
      pulse_done();
      tick(3);
      check("stray_done", 64'(op_count), 64'd1);
      check("stray_starts", 64'(start_cnt - base), 64'd2);
      check("tmo_sticky", 64'(err_timeout), 64'd1);

      // reset while waiting with two queued words
      do_reset();
      base = start_cnt;
      push_word(64'h02_00000000007000, 1'b1);
      push_word(64'h01_00000000008000, 1'b0);
      push_word(64'h01_00000000009000, 1'b0);
      wait_starts(base + 1);
      tick(1);
      check("midrst_level_pre", 64'(fifo_level), 64'd2);
      check("midrst_mode_pre", 64'(bus.ntt_mode), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_state();
      tick(1);
      rst = 1'b0;
      tick(10);
      check("midrst_starts", 64'(start_cnt - base), 64'd1);
      check("midrst_level", 64'(fifo_level), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
